// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial wide adder: nibble width and FSM encoding.
package nsa_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_fourbitadder.sv
// Combinational 4-bit ripple adder slice shared by the ALU wide-add datapath.
module fourbitadder (
    input  logic [3:0] e,
    input  logic [3:0] f,
    input  logic       carry_in,
    output logic [3:0] sum,
    output logic       carry_out
);

    // Plain 5-bit add; the top bit is the carry out of the slice.
    assign {carry_out, sum} = {1'b0, e} + {1'b0, f} + {4'b0000, carry_in};

endmodule

// File: rtl/nibble_serial_adder.sv
// Sequencer that adds two NIBBLES*4-bit operands one nibble per clock through a
// single fourbitadder, LSB nibble first, and holds the full result for a
// valid/ready consumer.
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                      cin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] result,
    output logic                      cout,
    output logic                      ovf,
    output logic                      busy
);

    localparam int W      = NIBBLE_W * NIBBLES;
    localparam int IDX_W  = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int BASE_W = $clog2(W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t            state;
    state_t            next_state;
    logic [W-1:0]      a_reg;
    logic [W-1:0]      b_reg;
    logic              carry_reg;
    logic [IDX_W-1:0]  idx;
    logic [BASE_W-1:0] nib_base;
    logic [NIBBLE_W-1:0] nib_a;
    logic [NIBBLE_W-1:0] nib_b;
    logic [NIBBLE_W-1:0] nib_sum;
    logic              nib_cout;
    logic              accept;
    logic              last_nibble;

    // Select the current operand nibbles; the bit offset is the index times four.
    always_comb begin
        nib_base    = BASE_W'({idx, 2'b00});
        nib_a       = a_reg[nib_base +: NIBBLE_W];
        nib_b       = b_reg[nib_base +: NIBBLE_W];
        last_nibble = (idx == LAST_IDX);
    end

    fourbitadder u_add (
        .e         (nib_a),
        .f         (nib_b),
        .carry_in  (carry_reg),
        .sum       (nib_sum),
        .carry_out (nib_cout)
    );

    // Next-state decode; in_ready is already a registered IDLE flag so the accept needs no state term.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    accept     = 1'b1;
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_nibble) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // State, registered status flags and the whole datapath; the flags decode the next state so they track it with no extra cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
        end else begin
            state     <= next_state;
            in_ready  <= (next_state == ST_IDLE);
            out_valid <= (next_state == ST_DONE);
            busy      <= (next_state == ST_RUN);
            if (accept) begin
                a_reg     <= a;
                b_reg     <= b;
                carry_reg <= cin;
                idx       <= '0;
            end
            if (state == ST_RUN) begin
                result[nib_base +: NIBBLE_W] <= nib_sum;
                carry_reg <= nib_cout;
                if (last_nibble) begin
                    cout <= nib_cout;
                    ovf  <= (a_reg[W-1] == b_reg[W-1]) && (nib_sum[NIBBLE_W-1] != a_reg[W-1]);
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized self-checking bench for nibble_serial_adder (4-nibble and 1-nibble builds).
module tb_nibble_serial_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        cout;
    logic        ovf;
    logic        busy;

    logic        in_valid1;
    logic        in_ready1;
    logic [3:0]  a1;
    logic [3:0]  b1;
    logic        cin1;
    logic        out_valid1;
    logic        out_ready1;
    logic [3:0]  result1;
    logic        cout1;
    logic        ovf1;
    logic        busy1;

    int n_checks = 0;
    int n_pass   = 0;

    nibble_serial_adder #(.NIBBLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout), .ovf(ovf), .busy(busy)
    );

    nibble_serial_adder #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .result(result1), .cout(cout1), .ovf(ovf1), .busy(busy1)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against the bench's expectation.
    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Reference: whole-word two's complement add, returns {ovf, cout, sum}.
    function automatic logic [17:0] ref_add(input logic [15:0] x, input logic [15:0] y, input logic c);
        logic [16:0] s;
        logic        v;
        s = {1'b0, x} + {1'b0, y} + {16'd0, c};
        v = (x[15] == y[15]) && (s[15] != x[15]);
        return {v, s[16], s[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair for a single cycle on the 4-nibble build.
    task automatic apply_stimulus(input logic [15:0] x, input logic [15:0] y, input logic c);
        in_valid = 1'b1;
        a = x;
        b = y;
        cin = c;
        tick();
        in_valid = 1'b0;
        check_output("busy_after_accept", busy, 1'b1);
        check_output("in_ready_after_accept", in_ready, 1'b0);
    endtask

    // Count cycles from the accept edge until out_valid, with a bound.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            if (!out_valid) lat++;
            else break;
        end
        if (!out_valid) check_output("done_timeout", 1'b0, 1'b1);
    endtask

    // Full transaction with optional backpressure, checked against the reference.
    task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y, input logic c, input int hold);
        logic [17:0] exp;
        int lat;
        exp = ref_add(x, y, c);
        apply_stimulus(x, y, c);
        wait_done(lat);
        check_output({tag, "_latency"}, lat, 4);
        for (int h = 0; h < hold; h++) begin
            tick();
            check_output({tag, "_hold_valid"}, out_valid, 1'b1);
            check_output({tag, "_hold_result"}, result, exp[15:0]);
        end
        check_output({tag, "_result"}, result, exp[15:0]);
        check_output({tag, "_cout"}, cout, exp[16]);
        check_output({tag, "_ovf"}, ovf, exp[17]);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_output({tag, "_valid_drop"}, out_valid, 1'b0);
        check_output({tag, "_ready_rise"}, in_ready, 1'b1);
    endtask

    initial begin
        logic [17:0] exp;
        int lat;
        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_in_ready", in_ready, 1'b1);
        check_output("rst_out_valid", out_valid, 1'b0);
        check_output("rst_busy", busy, 1'b0);
        check_output("rst_result", result, 16'h0000);
        check_output("rst_cout", cout, 1'b0);
        check_output("rst_ovf", ovf, 1'b0);
        rst_n = 1'b1;
        tick();

        // Directed cases from the plan.
        run_op("add7_6", 16'h0007, 16'h0006, 1'b1, 0);
        run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 0);
        run_op("posovf", 16'h7FFF, 16'h0001, 1'b0, 0);
        run_op("negovf", 16'h8000, 16'h8000, 1'b0, 0);

        // Backpressure with new operands offered while DONE is held.
        apply_stimulus(16'h1200, 16'h0034, 1'b0);
        wait_done(lat);
        check_output("bp_latency", lat, 4);
        in_valid = 1'b1; a = 16'h5555; b = 16'h1111; cin = 1'b1;
        for (int h = 0; h < 5; h++) begin
            tick();
            check_output("bp_out_valid", out_valid, 1'b1);
            check_output("bp_result", result, 16'h1234);
            check_output("bp_in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_output("bp_release_valid", out_valid, 1'b0);
        check_output("bp_release_ready", in_ready, 1'b1);
        check_output("bp_result_kept", result, 16'h1234);
        check_output("bp_no_capture_busy", busy, 1'b0);

        // Asynchronous reset during nibble 2.
        apply_stimulus(16'hABCD, 16'h1111, 1'b0);
        tick();
        tick();
        check_output("mid_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check_output("mid_rst_in_ready", in_ready, 1'b1);
        check_output("mid_rst_out_valid", out_valid, 1'b0);
        check_output("mid_rst_busy", busy, 1'b0);
        check_output("mid_rst_result", result, 16'h0000);
        check_output("mid_rst_cout", cout, 1'b0);
        check_output("mid_rst_ovf", ovf, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_op("post_rst", 16'h0001, 16'h0001, 1'b0, 0);

        // Randomized operands and backpressure.
        for (int k = 0; k < 25; k++) begin
            run_op("rand", 16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        // Single-nibble build.
        in_valid1 = 1'b1; a1 = 4'hF; b1 = 4'h1; cin1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        lat = 0;
        while (!out_valid1 && lat < 10) begin
            tick();
            lat++;
        end
        exp = {1'b0, 1'b1, 16'h0001};
        check_output("n1_latency", lat, 1);
        check_output("n1_result", result1, exp[3:0]);
        check_output("n1_cout", cout1, exp[16]);
        check_output("n1_ovf", ovf1, exp[17]);
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        check_output("n1_valid_drop", out_valid1, 1'b0);
        check_output("n1_ready_rise", in_ready1, 1'b1);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
